// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared types and constants for the pipeline control slice
// Contents:
//   state_e      controller FSM states (IDLE, RUN, DRAIN, HALTED)
//   REG_AW_DEF   default register-address width
//   DRAIN_DEPTH  cycles spent in DRAIN before the pipeline is empty
package proc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

  localparam int         REG_AW_DEF  = 3;
  localparam logic [1:0] DRAIN_DEPTH = 2'd2;

endpackage

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use hazard compare
// Ports:
//   id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2  ID-stage sources
//   ex_valid, ex_is_load, ex_wr_en, ex_rd                EX-stage producer
//   load_use                                             ID needs a value the EX load has not produced yet
module hazard_detect
  import proc_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              ex_valid,
  input  logic              ex_is_load,
  input  logic              ex_wr_en,
  input  logic [REG_AW-1:0] ex_rd,
  output logic              load_use
);

  logic producer;
  logic rs1_hit;
  logic rs2_hit;

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign producer = ex_valid & ex_is_load & ex_wr_en & (ex_rd != '0);
  assign rs1_hit  = id_uses_rs1 & (id_rs1 == ex_rd);
  assign rs2_hit  = id_uses_rs2 & (id_rs2 == ex_rd);
  assign load_use = id_valid & producer & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipeline_controller.sv
// rtl/pipeline_controller.sv - stall/flush/drain controller for a short in-order pipeline
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   id_* / ex_*                     ID and EX stage status used for hazard and branch decisions
//   ex_branch_taken, ex_busy        EX redirect and multi-cycle busy
//   halt_req, resume                drain-and-halt request, leave halt
//   pc_en, if_id_en, if_id_flush    PC and IF/ID register control
//   id_ex_en, id_ex_flush           ID/EX register control
//   halted, stall_cnt               pipeline frozen empty, saturating stall-cycle count
module pipeline_controller
  import proc_pkg::*;
#(
  parameter int REG_AW   = REG_AW_DEF,
  parameter int STALL_CW = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic [REG_AW-1:0]   id_rs1,
  input  logic [REG_AW-1:0]   id_rs2,
  input  logic                id_uses_rs1,
  input  logic                id_uses_rs2,
  input  logic                ex_valid,
  input  logic                ex_is_load,
  input  logic                ex_wr_en,
  input  logic [REG_AW-1:0]   ex_rd,
  input  logic                ex_branch_taken,
  input  logic                ex_busy,
  input  logic                halt_req,
  input  logic                resume,
  output logic                pc_en,
  output logic                if_id_en,
  output logic                if_id_flush,
  output logic                id_ex_en,
  output logic                id_ex_flush,
  output logic                halted,
  output logic [STALL_CW-1:0] stall_cnt
);

  state_e        state_q, state_d;
  logic [1:0]    drain_q, drain_d;
  logic [STALL_CW-1:0] stall_q;
  logic          stall_inc;
  logic          load_use;
  logic          branch;

  hazard_detect #(.REG_AW(REG_AW)) u_hazard (
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_valid    (ex_valid),
    .ex_is_load  (ex_is_load),
    .ex_wr_en    (ex_wr_en),
    .ex_rd       (ex_rd),
    .load_use    (load_use)
  );

  assign branch = ex_valid & ex_branch_taken;

  always_comb begin
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_en    = 1'b0;
    id_ex_flush = 1'b0;
    halted      = 1'b0;
    stall_inc   = 1'b0;
    state_d     = state_q;
    drain_d     = drain_q;

    case (state_q)
      ST_IDLE: begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        state_d     = ST_RUN;
      end

      ST_RUN: begin
        if (branch) begin
          // Redirect: fetch the target, squash both younger instructions.
          pc_en       = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (ex_busy) begin
          stall_inc = 1'b1;
        end else if (load_use) begin
          // Hold IF and ID, push a bubble into EX until the load data exists.
          id_ex_en    = 1'b1;
          id_ex_flush = 1'b1;
          stall_inc   = 1'b1;
        end else begin
          pc_en    = 1'b1;
          if_id_en = 1'b1;
          id_ex_en = 1'b1;
          if (halt_req) begin
            state_d = ST_DRAIN;
            drain_d = DRAIN_DEPTH;
          end
        end
      end

      ST_DRAIN: begin
        if (branch) begin
          pc_en       = 1'b1;
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (ex_busy) begin
          stall_inc = 1'b1;
        end else begin
          // Stop fetching and let instructions already in flight move on.
          if_id_flush = 1'b1;
          id_ex_en    = 1'b1;
          drain_d     = drain_q - 2'd1;
          if (drain_q <= 2'd1) begin
            drain_d = 2'd0;
            state_d = ST_HALTED;
          end
        end
      end

      ST_HALTED: begin
        halted = 1'b1;
        if (resume) begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      drain_q <= 2'd0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      if (stall_inc && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  assign stall_cnt = stall_q;

endmodule
